fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Fetch-side sequencer feeding decode. Generates sequential 16-byte-aligned line addresses, issues them to
//   instruction memory with a bounded number of outstanding requests, buffers in-order responses in a FIFO,
//   and presents that FIFO to decode through the fetch_rd_en/fetch_rd_valid/fetch_instr/fetch_param/fetch_empty port set.
//   Handles ci_flush redirects by discarding buffered and in-flight lines and restarting at the redirect PC.
// PARAMETERS
//   DATA_WIDTH       128       instruction line width in bits (one line = DATA_WIDTH/8 bytes = 16)
//   ADDR_WIDTH       40        PC width in bits
//   FIFO_DEPTH       8         line buffer entries, power of 2, >= MAX_OUTSTANDING
//   MAX_OUTSTANDING  4         maximum imem requests in flight
//   RESET_PC         'h1_0000  first fetch address after reset
// PORTS
//   clk             in   1             clock, all logic on rising edge
//   rst             in   1             synchronous active-high reset
//   imem_req_valid  out  1             request valid
//   imem_req_ready  in   1             memory accepts request this cycle
//   imem_req_addr   out  ADDR_WIDTH    line address, low 4 bits always 0
//   imem_rsp_valid  in   1             in-order response valid (always accepted)
//   imem_rsp_data   in   DATA_WIDTH    line data
//   imem_rsp_err    in   1             access fault for this line
//   fetch_rd_en     in   1             decode pops one entry
//   fetch_rd_valid  out  1             fetch_instr/fetch_param valid (1 cycle after accepted pop)
//   fetch_instr     out  DATA_WIDTH    popped line
//   fetch_param     out  ADDR_WIDTH+1  {line PC, fault}
//   fetch_empty     out  1             FIFO has no entries
//   ci_flush        in   1             redirect request, single-cycle pulse
//   ci_flush_pc     in   ADDR_WIDTH    redirect target; low 4 bits ignored (aligned down)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0;
//     imem_req_valid=0, imem_req_addr=0, fetch_rd_valid=0, fetch_instr=0, fetch_param=0, fetch_empty=1.
//     Reset mid-operation abandons everything; responses arriving after reset release are not counted (memory is reset with us).
//   FSM: IDLE -> FETCH unconditionally next cycle.
//     FETCH: request when outstanding + fifo_count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING (slot reserved per request,
//       so a response never finds the FIFO full). On valid&ready: outstanding++, pc += 16 (wraps mod 2^ADDR_WIDTH).
//       imem_req_valid once raised holds with stable addr until ready, unless flush/rst.
//     Response with err=1 pushes entry with fault=1 -> HALT; later responses up to that point still pushed normally.
//     HALT: no new requests; in-flight non-stale responses still pushed; leaves only via ci_flush.
//     DRAIN: entered on ci_flush when stale requests remain; no requests; drop responses while drop_cnt>0; drop_cnt==0 -> FETCH.
//   ci_flush (any state except IDLE): same cycle clears FIFO, deasserts imem_req_valid next cycle, pc = ci_flush_pc & ~'hF.
//     drop_cnt = outstanding + (req accepted this cycle) - (rsp arriving this cycle, which is itself dropped); outstanding := 0.
//     Next state DRAIN if drop_cnt>0 else FETCH. A flush while in DRAIN adds to existing drop_cnt.
//   Response counting: each non-dropped rsp decrements outstanding and pushes {data, pc_of_line, err}; per-line PC tracked
//     by rsp_pc register advancing +16 per push (loaded with new pc on flush/reset).
//   Read side: fetch_empty = (count==0), combinational from registered state. fetch_rd_en with fetch_empty=1 is ignored.
//     Accepted pop in cycle N -> fetch_rd_valid=1 with data in N+1; fetch_instr/param hold last value when fetch_rd_valid=0.
//     Push and pop in same cycle: count unchanged; pop of empty FIFO never bypasses same-cycle push.
//     ci_flush wins over same-cycle pop: no fetch_rd_valid next cycle.
//   Pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// TESTING
//   1 Reset release, ready=1, 1-cycle rsp latency, rd_en=1 always -> addrs 0x10000,0x10010,...; fetch_param PCs match, fault=0.
//   2 rd_en=0, ready=1 -> exactly FIFO_DEPTH(8) requests issued, count=8, imem_req_valid=0 until a pop frees a slot.
//   3 ready=0 for 5 cycles -> req_valid and addr stable; rsp latency 10 -> outstanding caps at 4.
//   4 3 in flight, ci_flush with pc 0x2345F -> FIFO empty next cycle, 3 stale rsps dropped, next req addr 0x23450.
//   5 rsp_err on line 0x10020 -> entry fault=1 pushed, no further requests; ci_flush to 0x10000 resumes fetching.
//   6 pc=0xFF_FFFF_FFF0 -> next request 0x00_0000_0000; pop+push same cycle at full holds count; rst mid-run -> all outputs reset values.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch-side sequencer feeding decode. Walks sequential 16-byte line
//   addresses, keeps a bounded number of instruction-memory requests in
//   flight, buffers the in-order responses in a small FIFO and hands that
//   FIFO to decode. A ci_flush redirect throws away buffered and in-flight
//   lines and restarts fetching at the (line-aligned) redirect PC.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   imem_req_*       request channel: valid/ready handshake, line address
//   imem_rsp_*       in-order response channel: valid, line data, fault flag
//   fetch_rd_en      decode pops one entry (ignored while fetch_empty)
//   fetch_rd_valid   popped entry is on fetch_instr/fetch_param this cycle
//   fetch_instr      popped line data
//   fetch_param      {line PC, fault} of the popped line
//   fetch_empty      line buffer holds no entries
//   ci_flush(_pc)    single-cycle redirect pulse and its target PC
module fetch_ctrl #(
   parameter int DATA_WIDTH      = 128,
   parameter int ADDR_WIDTH      = 40,
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h1_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  imem_rsp_err,
   input  logic                  fetch_rd_en,
   output logic                  fetch_rd_valid,
   output logic [DATA_WIDTH-1:0] fetch_instr,
   output logic [ADDR_WIDTH:0]   fetch_param,
   output logic                  fetch_empty,
   input  logic                  ci_flush,
   input  logic [ADDR_WIDTH-1:0] ci_flush_pc
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
   localparam int DROP_W  = OUT_W + 1;
   localparam int OCC_W   = CNT_W + 1;
   localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~(LINE_BYTES - 1'b1);

   typedef enum logic [1:0] {IDLE, FETCH, HALT, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
   logic [OUT_W-1:0]        out_q, out_d;
   logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]      mem_d [FIFO_DEPTH];
   logic                    req_valid_q, req_valid_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDR_WIDTH:0]     param_q, param_d;

   logic                    flush_act;
   logic                    req_fire;
   logic                    push;
   logic                    pop;
   logic [OCC_W-1:0]        occ;
   logic                    room;

   assign flush_act = ci_flush && (state_q != IDLE);
   assign req_fire  = req_valid_q && imem_req_ready;
   // Responses are only buffered while fetching or halted; in DRAIN they are stale,
   // and one arriving in a flush cycle belongs to the abandoned stream.
   assign push      = imem_rsp_valid && ((state_q == FETCH) || (state_q == HALT)) && !flush_act;
   assign pop       = fetch_rd_en && (count_q != '0) && !flush_act;

   // State register plus every other flop of the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         rsp_pc_q    <= RESET_PC;
         out_q       <= '0;
         drop_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         rd_valid_q  <= 1'b0;
         instr_q     <= '0;
         param_q     <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rsp_pc_q    <= rsp_pc_d;
         out_q       <= out_d;
         drop_cnt_q  <= drop_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         rd_valid_q  <= rd_valid_d;
         instr_q     <= instr_d;
         param_q     <= param_d;
      end
   end

   // Line storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Count of stale responses still to be discarded. A flush inherits everything in
   // flight (including a request accepted in the flush cycle); a response arriving
   // in the flush cycle is itself one of the stale ones and is consumed immediately.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (flush_act) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(out_q) + DROP_W'(req_fire);
         if (imem_rsp_valid && (drop_cnt_d != '0)) begin
            drop_cnt_d = drop_cnt_d - 1'b1;
         end
      end else if ((state_q == DRAIN) && imem_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   // Next-state logic. A flush overrides everything outside IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (push && imem_rsp_err) state_d = HALT;
         HALT:    state_d = HALT;
         DRAIN:   if (drop_cnt_d == '0) state_d = FETCH;
         default: state_d = IDLE;
      endcase
      if (flush_act) begin
         state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
      end
   end

   // Datapath and registered outputs: PC stepping, FIFO push/pop, request issue.
   always_comb begin
      pc_d        = pc_q;
      rsp_pc_d    = rsp_pc_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_d       = mem_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      rd_valid_d  = 1'b0;
      instr_d     = instr_q;
      param_d     = param_q;

      if (req_fire) begin
         pc_d = pc_q + LINE_BYTES;
      end
      if (push) begin
         mem_d[wr_ptr_q] = {imem_rsp_data, rsp_pc_q, imem_rsp_err};
         wr_ptr_d        = wr_ptr_q + 1'b1;
         rsp_pc_d        = rsp_pc_q + LINE_BYTES;
      end
      if (pop) begin
         {instr_d, param_d} = mem_q[rd_ptr_q];
         rd_ptr_d           = rd_ptr_q + 1'b1;
         rd_valid_d         = 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      out_d   = out_q + OUT_W'(req_fire) - OUT_W'(push);

      if (flush_act) begin
         pc_d     = ci_flush_pc & LINE_MASK;
         rsp_pc_d = ci_flush_pc & LINE_MASK;
         out_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      // A request being raised reserves a FIFO slot as well as an outstanding slot,
      // so a pending request plus everything in flight can never overflow the buffer.
      occ  = OCC_W'(out_d) + OCC_W'(count_d);
      room = (out_d < OUT_W'(MAX_OUTSTANDING)) && (occ < OCC_W'(FIFO_DEPTH));

      // Once raised, a request holds its address until accepted (or flushed).
      if (flush_act) begin
         req_valid_d = 1'b0;
      end else if (!req_valid_q || req_fire) begin
         req_valid_d = (state_d == FETCH) && room;
         if (req_valid_d) begin
            req_addr_d = pc_d;
         end
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = req_addr_q;
   assign fetch_rd_valid = rd_valid_q;
   assign fetch_instr    = instr_q;
   assign fetch_param    = param_q;
   assign fetch_empty    = (count_q == '0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Bench for fetch_ctrl. A memory model answers accepted requests in order
//   after a programmable latency; every response that decode should later see
//   is queued as an expected entry, and an independent monitor compares each
//   fetch_rd_valid output against the head of that queue. Request addresses
//   are compared against the expected fetch PC sequence.
module tb_fetch_ctrl;

   localparam int DW = 128;
   localparam int AW = 40;
   localparam logic [AW-1:0] RESET_PC = 40'h1_0000;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
      bit            stale;
   } pend_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [AW:0]   param;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [DW-1:0] imem_rsp_data;
   logic          imem_rsp_err;
   logic          fetch_rd_en;
   logic          fetch_rd_valid;
   logic [DW-1:0] fetch_instr;
   logic [AW:0]   fetch_param;
   logic          fetch_empty;
   logic          ci_flush;
   logic [AW-1:0] ci_flush_pc;

   // Stimulus controls, applied at the next negedge by step().
   logic          rst_ctl, ready_ctl, rd_en_ctl, flush_ctl, err_en;
   logic [AW-1:0] flush_pc_ctl, err_addr;
   int            lat;

   // Model state.
   pend_t         pend[$];
   exp_t          exp_q[$];
   logic [AW-1:0] exp_pc;
   logic [AW-1:0] first_addr, second_addr;
   int            acc_idx, first_edge, edge_no, last_due;
   int            accept_cnt, max_pend, fault_cnt;

   int            tests;
   int            fails;

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .fetch_rd_en    (fetch_rd_en),
      .fetch_rd_valid (fetch_rd_valid),
      .fetch_instr    (fetch_instr),
      .fetch_param    (fetch_param),
      .fetch_empty    (fetch_empty),
      .ci_flush       (ci_flush),
      .ci_flush_pc    (ci_flush_pc)
   );

   always #5 clk = ~clk;

   // Line contents the memory returns for a given address.
   function automatic logic [DW-1:0] lineData(input logic [AW-1:0] a);
      return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0], {a[7:0], a[39:16]}, a[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // One cycle: drive inputs at the negedge for the coming rising edge and
   // update the memory model / expected queue for what that edge will do.
   task automatic step();
      pend_t p;
      exp_t  e;
      @(negedge clk);
      edge_no++;
      rst            = rst_ctl;
      imem_req_ready = ready_ctl;
      fetch_rd_en    = rd_en_ctl;
      ci_flush       = flush_ctl;
      ci_flush_pc    = flush_pc_ctl;
      flush_ctl      = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      if (rst_ctl) begin
         pend.delete();
         exp_q.delete();
         exp_pc   = RESET_PC;
         last_due = 0;
         acc_idx  = 0;
      end else begin
         if (imem_req_valid && ready_ctl) begin
            checkOutput("req_addr", DW'(imem_req_addr), DW'(exp_pc));
            accept_cnt++;
            if (acc_idx == 0) begin
               first_addr = imem_req_addr;
               first_edge = edge_no;
            end else if (acc_idx == 1) begin
               second_addr = imem_req_addr;
            end
            acc_idx++;
            p.addr  = imem_req_addr;
            p.due   = (edge_no + lat > last_due + 1) ? edge_no + lat : last_due + 1;
            p.stale = 1'b0;
            last_due = p.due;
            pend.push_back(p);
            exp_pc = exp_pc + 40'h10;
         end
         if (pend.size() > max_pend) max_pend = pend.size();
         if (pend.size() > 0 && pend[0].due <= edge_no) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = lineData(p.addr);
            imem_rsp_err   = err_en && (p.addr == err_addr);
            if (!p.stale && !ci_flush) begin
               e.data  = imem_rsp_data;
               e.param = {p.addr, imem_rsp_err};
               exp_q.push_back(e);
            end
         end
         if (ci_flush) begin
            exp_q.delete();
            for (int i = 0; i < pend.size(); i++) begin
               p = pend[i];
               p.stale = 1'b1;
               pend[i] = p;
            end
            exp_pc  = ci_flush_pc & ~40'hF;
            acc_idx = 0;
         end
      end
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_valid"}, DW'(imem_req_valid), DW'(0));
      checkOutput({tag, "_req_addr"},  DW'(imem_req_addr),  DW'(0));
      checkOutput({tag, "_rd_valid"},  DW'(fetch_rd_valid), DW'(0));
      checkOutput({tag, "_instr"},     fetch_instr,         DW'(0));
      checkOutput({tag, "_param"},     DW'(fetch_param),    DW'(0));
      checkOutput({tag, "_empty"},     DW'(fetch_empty),    DW'(1));
   endtask

   // Scoreboard monitor: every decode output must match the oldest expected line.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (fetch_rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL rd_unexpected: got param %h, required no output", fetch_param);
         end else begin
            e = exp_q.pop_front();
            checkOutput("rd_instr", fetch_instr, e.data);
            checkOutput("rd_param", DW'(fetch_param), DW'(e.param));
            if (fetch_param[0]) fault_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int guard;
      clk = 0; rst = 1; imem_req_ready = 0; fetch_rd_en = 0; ci_flush = 0;
      ci_flush_pc = '0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
      rst_ctl = 1; ready_ctl = 0; rd_en_ctl = 0; flush_ctl = 0; flush_pc_ctl = '0;
      err_en = 0; err_addr = '0; lat = 1;
      tests = 0; fails = 0; edge_no = 0; last_due = 0; acc_idx = 0; first_edge = 0;
      accept_cnt = 0; max_pend = 0; fault_cnt = 0; exp_pc = RESET_PC;
      first_addr = '0; second_addr = '0;

      // Reset values, then streaming fetch with 1-cycle memory and decode always popping.
      applyStimulus(3);
      checkResetOutputs("reset");
      rst_ctl = 0; ready_ctl = 1; rd_en_ctl = 1; accept_cnt = 0;
      applyStimulus(40);
      checkOutput("t1_first_addr", DW'(first_addr), DW'(40'h1_0000));
      checkOutput("t1_progress", DW'(accept_cnt >= 20), DW'(1));

      // Decode stalled: exactly FIFO_DEPTH lines fetched, then a single pop frees one slot.
      rst_ctl = 1; applyStimulus(2);
      rst_ctl = 0; rd_en_ctl = 0; accept_cnt = 0;
      applyStimulus(30);
      checkOutput("t2_req_count", DW'(accept_cnt), DW'(8));
      checkOutput("t2_not_empty", DW'(fetch_empty), DW'(0));
      checkOutput("t2_req_idle", DW'(imem_req_valid), DW'(0));
      rd_en_ctl = 1; applyStimulus(1); rd_en_ctl = 0;
      guard = 0;
      while (accept_cnt < 9 && guard < 10) begin
         step();
         guard++;
      end
      checkOutput("t2_refill", DW'(accept_cnt), DW'(9));
      // Steady pop/push at a nearly full buffer, then refill and flush with a pop pending.
      rd_en_ctl = 1; applyStimulus(20);
      rd_en_ctl = 0; applyStimulus(12);
      checkOutput("t2_full_not_empty", DW'(fetch_empty), DW'(0));
      rd_en_ctl = 1; flush_ctl = 1; flush_pc_ctl = 40'h1_0000;
      applyStimulus(1);
      applyStimulus(1);
      checkOutput("t2_flush_empty", DW'(fetch_empty), DW'(1));
      checkOutput("t2_flush_no_rd", DW'(fetch_rd_valid), DW'(0));

      // Memory stalls: request held with a stable address; long latency caps in-flight count.
      ready_ctl = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("t3_hold_valid", DW'(imem_req_valid), DW'(1));
         checkOutput("t3_hold_addr", DW'(imem_req_addr), DW'(40'h1_0000));
      end
      lat = 10; ready_ctl = 1; max_pend = 0;
      applyStimulus(40);
      checkOutput("t3_max_outstanding", DW'(max_pend), DW'(4));

      // Flush with three requests in flight: stale lines dropped, restart at aligned PC.
      rst_ctl = 1; applyStimulus(2);
      rst_ctl = 0; ready_ctl = 1; rd_en_ctl = 1; lat = 10;
      guard = 0;
      while (pend.size() < 3 && guard < 20) begin
         step();
         guard++;
      end
      checkOutput("t4_in_flight", DW'(pend.size()), DW'(3));
      ready_ctl = 0; flush_ctl = 1; flush_pc_ctl = 40'h2_345F;
      applyStimulus(1);
      guard = last_due;
      applyStimulus(1);
      checkOutput("t4_flush_empty", DW'(fetch_empty), DW'(1));
      lat = 1; ready_ctl = 1;
      applyStimulus(40);
      checkOutput("t4_restart_addr", DW'(first_addr), DW'(40'h2_3450));
      checkOutput("t4_restart_after_drain", DW'(first_edge > guard), DW'(1));

      // Access fault on line 0x10020: faulting entry delivered, fetching stops until flush.
      rst_ctl = 1; applyStimulus(2);
      rst_ctl = 0; err_en = 1; err_addr = 40'h1_0020; fault_cnt = 0;
      applyStimulus(20);
      checkOutput("t5_halt_req_idle", DW'(imem_req_valid), DW'(0));
      accept_cnt = 0;
      applyStimulus(10);
      checkOutput("t5_halt_no_req", DW'(accept_cnt), DW'(0));
      checkOutput("t5_fault_seen", DW'(fault_cnt), DW'(1));
      err_en = 0; flush_ctl = 1; flush_pc_ctl = 40'h1_0000;
      applyStimulus(21);
      checkOutput("t5_resume_addr", DW'(first_addr), DW'(40'h1_0000));
      checkOutput("t5_resume_progress", DW'(accept_cnt > 0), DW'(1));

      // Address wrap at the top of the PC space, then reset in the middle of traffic.
      flush_ctl = 1; flush_pc_ctl = 40'hFF_FFFF_FFF5;
      applyStimulus(21);
      checkOutput("t6_top_addr", DW'(first_addr), DW'(40'hFF_FFFF_FFF0));
      checkOutput("t6_wrap_addr", DW'(second_addr), DW'(40'h0));
      rst_ctl = 1; applyStimulus(2);
      checkResetOutputs("midrst");
      rst_ctl = 0; applyStimulus(20);
      ready_ctl = 0; applyStimulus(20);
      checkOutput("t6_drained", DW'(exp_q.size()), DW'(0));
      checkOutput("t6_final_empty", DW'(fetch_empty), DW'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
